// File: rtl/lcd_phrase_scheduler_pkg.sv
// Shared definitions for the LCD phrase scheduler: phrase codes (also used by
// the phrase bank), FSM state encoding and the time/alert phrase choice.
package lcd_phrase_scheduler_pkg;

    typedef enum logic [1:0] {
        PH_STATUS = 2'd0,
        PH_TIME   = 2'd1,
        PH_CONFIG = 2'd2,
        PH_ALERT  = 2'd3
    } phrase_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int MIN_HOLD_DEF     = 100;
    localparam int WAIT_TIMEOUT_DEF = 250;
    localparam int ALERT_THRESH_DEF = 5;

    // Zero means the countdown has expired, so it never counts as an alert.
    function automatic phrase_t time_phrase(input logic [6:0] t, input int thresh);
        return ((t != 7'd0) && (int'(t) <= thresh)) ? PH_ALERT : PH_TIME;
    endfunction

endpackage

// File: rtl/lcd_phrase_scheduler_if.sv
// Requester inputs, display-control handshake and phrase outputs of the scheduler.
// Handshake: Refresh is a one-cycle start pulse issued only while DisplayBusy=0;
// DisplayDone is a one-cycle completion pulse, honoured only while waiting for it.
interface lcd_phrase_scheduler_if;
    import lcd_phrase_scheduler_pkg::*;

    logic [1:0] StateFlag;
    logic       ConfigMode;
    logic [6:0] timeRemaining;
    logic       DisplayBusy;
    logic       DisplayDone;
    logic [1:0] PhraseSel;
    logic       Refresh;
    logic       TimeoutErr;
    state_t     dbg_state;

    modport master (
        output StateFlag, ConfigMode, timeRemaining, DisplayBusy, DisplayDone,
        input  PhraseSel, Refresh, TimeoutErr, dbg_state
    );

    modport slave (
        input  StateFlag, ConfigMode, timeRemaining, DisplayBusy, DisplayDone,
        output PhraseSel, Refresh, TimeoutErr, dbg_state
    );

endinterface

// File: rtl/lcd_req_latch.sv
// Change/edge detection for the three requesters with set-wins pending flags.
// A new event arriving in the same cycle as its grant keeps the flag set.
module lcd_req_latch (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_state_flag,
    input  logic       i_config_mode,
    input  logic [6:0] i_time,
    input  logic       i_clr_state,
    input  logic       i_clr_cfg,
    input  logic       i_clr_time,
    output logic       o_pend_state,
    output logic       o_pend_cfg,
    output logic       o_pend_time
);
    logic [1:0] r_last_state;
    logic [6:0] r_last_time;
    logic       r_last_cfg;
    logic       r_pend_state;
    logic       r_pend_cfg;
    logic       r_pend_time;

    logic w_ev_state;
    logic w_ev_cfg;
    logic w_ev_time;

    // Leaving config mode repaints the status phrase; time changes during config are dropped.
    assign w_ev_state = (i_state_flag != r_last_state) || (r_last_cfg && !i_config_mode);
    assign w_ev_cfg   = !r_last_cfg && i_config_mode;
    assign w_ev_time  = (i_time != r_last_time) && !i_config_mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_state <= i_state_flag;
            r_last_time  <= i_time;
            r_last_cfg   <= i_config_mode;
            r_pend_state <= 1'b1;
            r_pend_cfg   <= 1'b0;
            r_pend_time  <= 1'b0;
        end else begin
            r_last_state <= i_state_flag;
            r_last_time  <= i_time;
            r_last_cfg   <= i_config_mode;
            r_pend_state <= w_ev_state || (r_pend_state && !i_clr_state);
            r_pend_cfg   <= w_ev_cfg   || (r_pend_cfg   && !i_clr_cfg);
            r_pend_time  <= w_ev_time  || (r_pend_time  && !i_clr_time);
        end
    end

    assign o_pend_state = r_pend_state;
    assign o_pend_cfg   = r_pend_cfg;
    assign o_pend_time  = r_pend_time;

endmodule

// File: rtl/lcd_phrase_scheduler.sv
// Chooses the LCD phrase by priority (state > config > time), starts the display
// write, waits for completion or timeout, then holds the phrase a minimum time.
module lcd_phrase_scheduler
    import lcd_phrase_scheduler_pkg::*;
#(
    parameter int MIN_HOLD     = MIN_HOLD_DEF,
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF,
    parameter int ALERT_THRESH = ALERT_THRESH_DEF
) (
    input logic                    clock500Hz,
    input logic                    reset,
    lcd_phrase_scheduler_if.slave  bus
);
    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_cnt;
    phrase_t    r_phrase;
    logic       r_timeout_err;

    logic    w_pend_state, w_pend_cfg, w_pend_time;
    logic    w_clr_state, w_clr_cfg, w_clr_time;
    logic    w_load;
    phrase_t w_next_phrase;
    logic    w_refresh;
    logic    w_cnt_clr;
    logic    w_cnt_inc;
    logic    w_set_err;

    lcd_req_latch u_req_latch (
        .clk           (clock500Hz),
        .reset         (reset),
        .i_state_flag  (bus.StateFlag),
        .i_config_mode (bus.ConfigMode),
        .i_time        (bus.timeRemaining),
        .i_clr_state   (w_clr_state),
        .i_clr_cfg     (w_clr_cfg),
        .i_clr_time    (w_clr_time),
        .o_pend_state  (w_pend_state),
        .o_pend_cfg    (w_pend_cfg),
        .o_pend_time   (w_pend_time)
    );

    always_comb begin
        w_next_state  = r_state;
        w_clr_state   = 1'b0;
        w_clr_cfg     = 1'b0;
        w_clr_time    = 1'b0;
        w_load        = 1'b0;
        w_next_phrase = r_phrase;
        w_refresh     = 1'b0;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
        w_set_err     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pend_state) begin
                    w_load        = 1'b1;
                    w_next_phrase = PH_STATUS;
                    w_clr_state   = 1'b1;
                    w_next_state  = ST_ISSUE;
                end else if (w_pend_cfg) begin
                    w_load        = 1'b1;
                    w_next_phrase = PH_CONFIG;
                    w_clr_cfg     = 1'b1;
                    w_next_state  = ST_ISSUE;
                end else if (w_pend_time) begin
                    w_load        = 1'b1;
                    w_next_phrase = time_phrase(bus.timeRemaining, ALERT_THRESH);
                    w_clr_time    = 1'b1;
                    w_next_state  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!bus.DisplayBusy) begin
                    w_refresh    = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.DisplayDone) begin
                    w_cnt_clr    = 1'b1;
                    w_next_state = ST_HOLD;
                end else if (r_cnt == 8'(WAIT_TIMEOUT - 1)) begin
                    w_set_err    = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_next_state = ST_HOLD;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_HOLD: begin
                if ((MIN_HOLD == 0) || (r_cnt == 8'(MIN_HOLD - 1))) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock500Hz) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            r_phrase      <= PH_STATUS;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_phrase <= w_next_phrase;
            end
            if (w_cnt_clr) begin
                r_cnt <= 8'd0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_set_err) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // Start pulse is suppressed in a reset cycle so a write is never half-issued.
    assign bus.Refresh    = w_refresh && !reset;
    assign bus.PhraseSel  = r_phrase;
    assign bus.TimeoutErr = r_timeout_err;
    assign bus.dbg_state  = r_state;

endmodule

// File: doc/lcd_phrase_scheduler.md
Name: lcd_phrase_scheduler

Overview:
- Decides which LCD phrase is shown and when, then triggers the display control unit to write it.
- Arbitrates three requesters: traffic state change, countdown update and operator configuration mode.
- Drives PhraseSel into the phrase bank and a start pulse into the display control unit, which runs in the 500 Hz display domain.
- Enforces a minimum hold time per phrase and a write timeout.

Parameters:
- MIN_HOLD, 100, cycles a phrase stays displayed before the next grant (200 ms at 500 Hz); legal range 0-255.
- WAIT_TIMEOUT, 250, maximum cycles to wait for DisplayDone after Refresh; legal range 1-255.
- ALERT_THRESH, 5, countdown value at or below which the alert phrase replaces the time phrase.

Ports:
- clock500Hz  in  1  display-domain clock.
- reset  in  1  synchronous, active-high.
- StateFlag  in  2  current traffic controller state.
- ConfigMode  in  1  high while the operator edits Tpv/Tsv/Ta.
- timeRemaining  in  7  countdown of the current state, in seconds.
- DisplayBusy  in  1  display control unit is writing.
- DisplayDone  in  1  one-cycle pulse when a phrase write completes.
- PhraseSel  out  2  phrase code: 0 STATUS, 1 TIME, 2 CONFIG, 3 ALERT.
- Refresh  out  1  one-cycle start pulse to the display control unit.
- TimeoutErr  out  1  sticky; set on write timeout, cleared only by reset.

Behaviour:
- Clocking: everything is synchronous to clock500Hz. The block contains no clock-domain crossing.
- Reset values: state IDLE; PhraseSel=0; Refresh=0; TimeoutErr=0; pend_time=0; pend_cfg=0; counters=0.
- pend_state=1 at reset, so the first phrase is painted without any input event.
- At reset, last_state and last_time capture the current inputs; last_cfg captures ConfigMode.
- Request flags (registered, set each cycle):
  - pend_state is set when StateFlag != last_state, or on a ConfigMode falling edge (restores the status phrase).
  - pend_cfg is set on a ConfigMode rising edge.
  - pend_time is set when timeRemaining != last_time and ConfigMode=0. Time events are dropped while ConfigMode=1.
  - last_* registers update every cycle.
- Flag clearing: a flag is cleared on its grant. If a new event for the same flag arrives in the grant cycle, set wins and the flag stays 1.
- Priority at grant: pend_state > pend_cfg > pend_time. Lower-priority flags stay pending.
- Phrase choice on a pend_time grant: ALERT if timeRemaining is between 1 and ALERT_THRESH inclusive, otherwise TIME. The value is sampled in the grant cycle.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if any flag is set, load PhraseSel, clear the granted flag and go to ISSUE. Otherwise stay.
  - ISSUE: if DisplayBusy=0, Refresh=1 for exactly this cycle, clear the timeout counter and go to WAIT. If DisplayBusy=1, hold with Refresh=0.
  - WAIT: on DisplayDone=1, go to HOLD and clear the hold counter. Otherwise, when the counter reaches WAIT_TIMEOUT-1, set TimeoutErr and go to HOLD.
  - HOLD: count to MIN_HOLD-1, then go to IDLE. MIN_HOLD=0 goes to IDLE on the next cycle. Requests are never preempted; they stay latched.
- PhraseSel changes only on IDLE->ISSUE and is stable through ISSUE, WAIT and HOLD.
- DisplayDone outside WAIT is ignored.
- Latency: an event at cycle t (flag visible at t+1) with the FSM in IDLE and not busy gives a grant at t+1 and Refresh at t+2.
- reset=1 in any state forces the reset values on the next edge. No Refresh is emitted in that cycle.

Decomposition:
- Shared package: phrase codes (PH_STATUS=0, PH_TIME=1, PH_CONFIG=2, PH_ALERT=3) and FSM state encodings. These codes are also used by the phrase bank.
- One natural sub-module, lcd_req_latch: edge/change detection plus set-wins pending flags for the three requesters. The FSM, counters and priority logic stay in the top module.

Test Plan:
- Power-up paint: reset for 2 cycles, DisplayBusy=0, Done returned 3 cycles after Refresh -> PhraseSel=0, Refresh pulses once at cycle 2 after release; then HOLD lasts 100 cycles, then IDLE.
- Priority: StateFlag 0->1 and timeRemaining 20->19 in the same cycle -> STATUS is written first, then TIME after the hold, for two Refresh pulses total.
- Alert: timeRemaining stepped 6->5 -> PhraseSel=3. Step 5->0 -> PhraseSel=1.
- Config: ConfigMode rises -> PhraseSel=2. timeRemaining changes while high -> no Refresh. ConfigMode falls -> PhraseSel=0 Refresh.
- Busy/timeout: hold DisplayBusy=1 for 10 cycles in ISSUE -> Refresh is delayed until Busy drops. Then never send Done -> TimeoutErr=1 after 250 cycles in WAIT and the FSM continues; reset clears TimeoutErr.
- Mid-operation reset: assert reset during WAIT -> all outputs take reset values next cycle, and a fresh STATUS paint follows.
